// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: default width and the modulo-k wrap rule.
// Combinational helpers only; no state, no flow control.
// Counts are carried at COUNTER_MAX_W bits, so callers must use N <= COUNTER_MAX_W.
package counter_pkg;

  localparam int COUNTER_N_DEFAULT = 2;
  localparam int COUNTER_MAX_W     = 32;

  // Increment is evaluated one bit wider so count+1 at all-ones cannot alias to 0.
  function automatic logic [COUNTER_MAX_W-1:0] next_count(
    input logic [COUNTER_MAX_W-1:0] count,
    input logic [COUNTER_MAX_W-1:0] k
  );
    logic [COUNTER_MAX_W:0] inc;
    inc = {1'b0, count} + {{COUNTER_MAX_W{1'b0}}, 1'b1};
    if (inc >= {1'b0, k}) begin
      return '0;
    end
    return inc[COUNTER_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/reg_async_n.sv
// N-bit D register, cleared to zero by an asynchronous active-low reset.
// Latency: one clock edge from d to q.
// No flow control; loads every edge.
module reg_async_n #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/counter_mod_k_count.sv
// Modulo-k edge counter with a live modulus: o_count cycles 0 .. k-1, k <= 1 holds at 0.
// Latency: o_count updates on each rising i_clk; first edge after reset release gives 1.
// No flow control; counts every edge while out of reset.
module counter_mod_k_count
  import counter_pkg::*;
#(
  parameter int N = COUNTER_N_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_k,
  output logic [N-1:0] o_count
);

  logic [N-1:0] next_cnt;

  // A count already at or above a freshly lowered k wraps straight to 0.
  assign next_cnt = N'(next_count(COUNTER_MAX_W'(o_count), COUNTER_MAX_W'(i_k)));

  reg_async_n #(
    .N (N)
  ) u_state (
    .clk   (i_clk),
    .rst_n (i_reset),
    .d     (next_cnt),
    .q     (o_count)
  );

endmodule

// File: tb/tb_counter_mod_k_count.sv
// Bench for counter_mod_k_count at N=2 and N=3: vector table, corner sequences, random run vs model.
module tb_counter_mod_k_count;

  logic       clk;
  logic       rst2_n;
  logic       rst3_n;
  logic [1:0] k2;
  logic [2:0] k3;
  logic [1:0] cnt2;
  logic [2:0] cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  counter_mod_k_count #(.N(2)) dut2 (
    .i_clk   (clk),
    .i_reset (rst2_n),
    .i_k     (k2),
    .o_count (cnt2)
  );

  counter_mod_k_count #(.N(3)) dut3 (
    .i_clk   (clk),
    .i_reset (rst3_n),
    .i_k     (k3),
    .o_count (cnt3)
  );

  // Rising edges at t = 0, 10, 20, ...
  initial begin
    clk = 1'b0;
    #0 clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] k;
    logic [1:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec rule with plain integers: step to count+1 unless that reaches k.
  function automatic int ref_next(input int c, input int k);
    int m;
    m = c + 1;
    return (m >= k) ? 0 : m;
  endfunction

  task automatic pulse_rst3();
    #1 rst3_n = 1'b0;
    #1 check("rst3_async", int'(cnt3), 0);
    #1 rst3_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[$];
    int   m2;
    int   m3;

    rst2_n = 1'b0;
    rst3_n = 1'b0;
    k2     = 2'd3;
    k3     = 3'd7;

    #1;
    check("reset_n2", int'(cnt2), 0);
    check("reset_n3", int'(cnt3), 0);
    #2 rst2_n = 1'b1;

    @(negedge clk);
    check("release_n2", int'(cnt2), 0);

    // k=3 sequence, then k=0 and k=1 hold at zero, then k=max for N=2.
    vecs = '{
      '{2'd3, 2'd1}, '{2'd3, 2'd2}, '{2'd3, 2'd0}, '{2'd3, 2'd1},
      '{2'd3, 2'd2}, '{2'd3, 2'd0}, '{2'd3, 2'd1}, '{2'd3, 2'd2},
      '{2'd3, 2'd0},
      '{2'd0, 2'd0}, '{2'd0, 2'd0}, '{2'd0, 2'd0}, '{2'd0, 2'd0}, '{2'd0, 2'd0},
      '{2'd1, 2'd0}, '{2'd1, 2'd0}, '{2'd1, 2'd0}, '{2'd1, 2'd0}, '{2'd1, 2'd0},
      '{2'd3, 2'd1}, '{2'd3, 2'd2}, '{2'd3, 2'd0}, '{2'd3, 2'd1}, '{2'd3, 2'd2}
    };
    foreach (vecs[i]) begin
      k2 = vecs[i].k;
      @(negedge clk);
      check($sformatf("vec[%0d]", i), int'(cnt2), int'(vecs[i].exp));
    end

    // Mid-run reset pulse between edges while count is 2.
    #1 rst2_n = 1'b0;
    #1 check("mid_rst_n2", int'(cnt2), 0);
    #1 rst2_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_rst_n2", int'(cnt2), (i + 1) % 3);
    end

    // N=3, k=7: two full cycles, never reaching 7.
    #2 rst3_n = 1'b1;
    k3 = 3'd7;
    #1 check("release_n3", int'(cnt3), 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("k7_cycle", int'(cnt3), (i + 1) % 7);
    end

    // k lowered below the running count.
    pulse_rst3();
    k3 = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("k6_run", int'(cnt3), i + 1);
    end
    k3 = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("k_lowered", int'(cnt3), i % 3);
    end

    // k raised mid-run with no restart.
    @(negedge clk);
    pulse_rst3();
    k3 = 3'd2;
    @(negedge clk);
    check("k2_run", int'(cnt3), 1);
    k3 = 3'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("k_raised", int'(cnt3), (i + 2) % 5);
    end

    // Random k changes and reset pulses against the integer model.
    #1 rst2_n = 1'b0; rst3_n = 1'b0;
    #1 rst2_n = 1'b1; rst3_n = 1'b1;
    m2 = 0;
    m3 = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) k2 = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) k3 = 3'($urandom_range(7));
      if ($urandom_range(19) == 0) begin
        #1 rst2_n = 1'b0; rst3_n = 1'b0;
        #1 check("rand_rst_n2", int'(cnt2), 0);
        check("rand_rst_n3", int'(cnt3), 0);
        #1 rst2_n = 1'b1; rst3_n = 1'b1;
        m2 = 0;
        m3 = 0;
      end
      m2 = ref_next(m2, int'(k2));
      m3 = ref_next(m3, int'(k3));
      @(negedge clk);
      check("rand_n2", int'(cnt2), m2);
      check("rand_n3", int'(cnt3), m3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
